// File: rtl/sine_burst_ctrl.sv
// sine_burst_ctrl: schedules the sine_gen 'send' input so that each burst plays
// a whole number of sine periods, followed by a programmable idle gap. A job is
// a fixed number of bursts, or an endless run when cfg_bursts is 0. An abort lets
// the current period finish so the waveform is never cut mid-cycle.
// Optional feature macro: SINE_BURST_SYNC_EN adds the period_sync trigger output.
module sine_burst_ctrl #(
  parameter int PERIOD_CYC = 80,
  parameter int CNT_W      = 16,
  parameter int BURST_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   cfg_periods,
  input  logic [CNT_W-1:0]   cfg_gap,
  input  logic [BURST_W-1:0] cfg_bursts,
  output logic               send,
  output logic               busy,
  output logic [BURST_W-1:0] burst_idx,
  output logic               done,
`ifdef SINE_BURST_SYNC_EN
  output logic               period_sync,
`endif
  output logic               aborted
);

  localparam int PH_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_q,     state_d;
  logic [PH_W-1:0]    phase_q,     phase_d;
  logic [CNT_W-1:0]   per_cnt_q,   per_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic [CNT_W-1:0]   periods_q,   periods_d;
  logic [CNT_W-1:0]   gap_q,       gap_d;
  logic [BURST_W-1:0] bursts_q,    bursts_d;
  logic [BURST_W-1:0] burst_idx_q, burst_idx_d;
  logic               send_q,      send_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               aborted_q,   aborted_d;

  logic wrap;
  logic last_period;
  logic last_burst;

  // Sine period boundary, last period of a burst, and last burst of a finite job.
  assign wrap        = (phase_q == PH_W'(PERIOD_CYC - 1));
  assign last_period = (per_cnt_q == periods_q - CNT_W'(1));
  assign last_burst  = (bursts_q != '0) && ((burst_idx_q + BURST_W'(1)) == bursts_q);

  // Next-state logic; registered outputs are derived from the next state so
  // they change on the same edge as the state itself.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    per_cnt_d   = per_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    periods_d   = periods_q;
    gap_d       = gap_q;
    bursts_d    = bursts_q;
    burst_idx_d = burst_idx_q;
    aborted_d   = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          periods_d   = cfg_periods;
          gap_d       = cfg_gap;
          bursts_d    = cfg_bursts;
          phase_d     = '0;
          per_cnt_d   = '0;
          gap_cnt_d   = '0;
          burst_idx_d = '0;
          aborted_d   = 1'b0;
          state_d     = (cfg_periods == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        phase_d = wrap ? '0 : phase_q + PH_W'(1);
        if (stop) begin
          // A stop exactly on a boundary has nothing left to flush.
          aborted_d = 1'b1;
          state_d   = wrap ? S_DONE : S_FLUSH;
        end else if (wrap) begin
          if (last_period) begin
            per_cnt_d = '0;
            if (last_burst) begin
              state_d = S_DONE;
            end else if (gap_q == '0) begin
              // Back-to-back bursts keep send high without a single idle clock.
              burst_idx_d = burst_idx_q + BURST_W'(1);
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else begin
            per_cnt_d = per_cnt_q + CNT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (gap_cnt_q == gap_q - CNT_W'(1)) begin
          phase_d     = '0;
          per_cnt_d   = '0;
          burst_idx_d = burst_idx_q + BURST_W'(1);
          state_d     = S_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end

      S_FLUSH: begin
        // send is already low; sine_gen plays out the rest of the period alone.
        if (wrap) begin
          phase_d = '0;
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    send_d = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      per_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      periods_q   <= '0;
      gap_q       <= '0;
      bursts_q    <= '0;
      burst_idx_q <= '0;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      per_cnt_q   <= per_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      periods_q   <= periods_d;
      gap_q       <= gap_d;
      bursts_q    <= bursts_d;
      burst_idx_q <= burst_idx_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign send      = send_q;
  assign busy      = busy_q;
  assign burst_idx = burst_idx_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

`ifdef SINE_BURST_SYNC_EN
  logic sync_q;

  // Trigger in the cycle sine_gen enters its first sample: one clock after phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= (state_q == S_RUN) && (phase_q == '0);
    end
  end

  assign period_sync = sync_q;
`endif

endmodule
